// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Contents:
//   state_t           - arbiter FSM state encoding
//   DEF_*             - default parameter values
//   rr_wrap()         - modulo-n index step used by the round-robin search
package uart_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Default parameter values
    localparam int unsigned DEF_NUM_REQ      = 4;
    localparam int unsigned DEF_DATA_BITS    = 8;
    localparam int unsigned DEF_BUSY_TIMEOUT = 16;

    // (base + off) mod n, assuming base < n and 1 <= off <= n.
    // A single conditional subtract keeps this valid for any n, not just powers of 2.
    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
        int unsigned sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage : uart_arb_pkg

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker.
// Searches last+1, last+2, ... (mod NUM_REQ) and returns the first set bit.
// Ports:
//   elig  in  NUM_REQ  eligible requester vector
//   last  in  ID_W     most recently served requester
//   found out 1        at least one requester is eligible
//   idx   out ID_W     chosen requester (0 when found is 0)
module uart_rr_picker
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig,
    input  logic [ID_W-1:0]    last,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W-1:0] cand;

    // First hit in rotated order wins; last itself is tried at the end of the round
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'(rr_wrap(32'(last), i, NUM_REQ));
            if (!found && elig[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule : uart_rr_picker

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// One byte is accepted per grant; the arbiter then drives tx_data/tx_start and
// follows tx_busy until the frame ends. A watchdog abandons a start that the
// transmitter never acknowledges.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req_valid    in  NUM_REQ            per-requester byte available
//   req_data     in  NUM_REQ*DATA_BITS  requester i byte at [i*DATA_BITS +: DATA_BITS]
//   req_mask     in  NUM_REQ            requester eligible when 1
//   req_ready    out NUM_REQ            one-hot accept pulse
//   tx_data      out DATA_BITS          byte to transmitter, held until next grant
//   tx_start     out 1                  start pulse to transmitter
//   tx_busy      in  1                  transmitter busy
//   grant_id     out ID_W               current or last granted requester
//   active       out 1                  transaction in flight
//   tx_done      out 1                  frame complete pulse
//   err_timeout  out 1                  watchdog expiry pulse
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
    parameter int unsigned DATA_BITS    = DEF_DATA_BITS,
    parameter int unsigned BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    parameter int unsigned ID_W         = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_mask,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_BITS-1:0]           tx_data,
    output logic                           tx_start,
    input  logic                           tx_busy,
    output logic [ID_W-1:0]                grant_id,
    output logic                           active,
    output logic                           tx_done,
    output logic                           err_timeout
);

    localparam int unsigned WD_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(BUSY_TIMEOUT);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

    state_t            state;
    logic [ID_W-1:0]   last;
    logic [WD_W-1:0]   wd;
    logic [WD_W-1:0]   wd_inc;
    logic [NUM_REQ-1:0] elig;
    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;

    assign elig = req_valid & req_mask;

    // Watchdog next value, saturating at all-ones instead of wrapping
    assign wd_inc = (wd == WD_MAX) ? wd : wd + WD_W'(1);

    // Rotating-priority search starting after the last served requester
    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .elig  (elig),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // FSM, watchdog and all output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= LAST_RST;
            wd          <= '0;
            req_ready   <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            grant_id    <= '0;
            active      <= 1'b0;
            tx_done     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle
            req_ready   <= '0;
            tx_start    <= 1'b0;
            tx_done     <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_id  <= pick_idx;
                        tx_data   <= req_data[32'(pick_idx) * DATA_BITS +: DATA_BITS];
                        req_ready <= NUM_REQ'(1) << pick_idx;
                        tx_start  <= 1'b1;
                        wd        <= '0;
                        active    <= 1'b1;
                        state     <= WAIT_BUSY;
                    end
                end

                WAIT_BUSY: begin
                    wd <= wd_inc;
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (wd_inc == WD_LIMIT) begin
                        // Transmitter never acknowledged: drop the byte and move on
                        err_timeout <= 1'b1;
                        last        <= grant_id;
                        active      <= 1'b0;
                        state       <= IDLE;
                    end
                end

                WAIT_DONE: begin
                    if (!tx_busy) begin
                        tx_done <= 1'b1;
                        last    <= grant_id;
                        active  <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    active <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 4-requester instance and a 3-requester
// instance, each with a simple transmitter model. Expected grants are queued as
// stimulus is applied and popped when tx_start appears.
module tb_uart_tx_arbiter;

    localparam int unsigned TMO      = 16;
    localparam int          BUSY_LEN = 20;

    logic clk;
    logic rst_n;

    // 4-requester instance
    logic [3:0]  req_valid4, req_mask4, req_ready4;
    logic [31:0] req_data4;
    logic [7:0]  tx_data4;
    logic        tx_start4, tx_busy4, active4, tx_done4, err_timeout4;
    logic [1:0]  grant_id4;

    // 3-requester instance
    logic [2:0]  req_valid3, req_mask3, req_ready3;
    logic [23:0] req_data3;
    logic [7:0]  tx_data3;
    logic        tx_start3, tx_busy3, active3, tx_done3, err_timeout3;
    logic [1:0]  grant_id3;

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .BUSY_TIMEOUT(TMO)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid4), .req_data(req_data4), .req_mask(req_mask4),
        .req_ready(req_ready4), .tx_data(tx_data4), .tx_start(tx_start4),
        .tx_busy(tx_busy4), .grant_id(grant_id4), .active(active4),
        .tx_done(tx_done4), .err_timeout(err_timeout4)
    );

    uart_tx_arbiter #(.NUM_REQ(3), .DATA_BITS(8), .BUSY_TIMEOUT(TMO)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_data(req_data3), .req_mask(req_mask3),
        .req_ready(req_ready3), .tx_data(tx_data3), .tx_start(tx_start3),
        .tx_busy(tx_busy3), .grant_id(grant_id3), .active(active3),
        .tx_done(tx_done3), .err_timeout(err_timeout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter models: busy rises the cycle after tx_start, lasts BUSY_LEN cycles
    bit busy_en4, busy_en3;
    int busy_cnt4, busy_cnt3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt4 <= 0;
        else if (tx_start4 && busy_en4) busy_cnt4 <= BUSY_LEN;
        else if (busy_cnt4 != 0) busy_cnt4 <= busy_cnt4 - 1;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_cnt3 <= 0;
        else if (tx_start3 && busy_en3) busy_cnt3 <= BUSY_LEN;
        else if (busy_cnt3 != 0) busy_cnt3 <= busy_cnt3 - 1;
    end
    assign tx_busy4 = (busy_cnt4 != 0);
    assign tx_busy3 = (busy_cnt3 != 0);

    // Scoreboard
    typedef struct {
        int         u;
        int         id;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int stray = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic start_of(input int u);
        return (u == 3) ? tx_start3 : tx_start4;
    endfunction
    function automatic logic done_of(input int u);
        return (u == 3) ? tx_done3 : tx_done4;
    endfunction
    function automatic logic err_of(input int u);
        return (u == 3) ? err_timeout3 : err_timeout4;
    endfunction
    function automatic logic active_of(input int u);
        return (u == 3) ? active3 : active4;
    endfunction
    function automatic logic [3:0] ready_of(input int u);
        return (u == 3) ? {1'b0, req_ready3} : req_ready4;
    endfunction
    function automatic logic [1:0] gid_of(input int u);
        return (u == 3) ? grant_id3 : grant_id4;
    endfunction
    function automatic logic [7:0] data_of(input int u);
        return (u == 3) ? tx_data3 : tx_data4;
    endfunction

    task automatic push_exp(input int u, input int id, input logic [7:0] d);
        exp_t e;
        e.u = u; e.id = id; e.data = d;
        exp_q.push_back(e);
    endtask

    // Wait for tx_start, pop the expected grant and compare; exp_lat 0 skips latency check
    task automatic next_grant(input int u, input int exp_lat, input string tag);
        exp_t e;
        int   n;
        bit   seen;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (start_of(u)) seen = 1'b1;
            else if (ready_of(u) != 4'd0) stray++;
        end
        check($sformatf("%s_seen", tag), 32'(seen), 32'd1);
        check($sformatf("%s_sb", tag), 32'(exp_q.size() != 0), 32'd1);
        if (seen && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s_id", tag), 32'(gid_of(u)), 32'(e.id));
            check($sformatf("%s_ready", tag), 32'(ready_of(u)), 32'd1 << e.id);
            check($sformatf("%s_data", tag), 32'(data_of(u)), 32'(e.data));
            check($sformatf("%s_active", tag), 32'(active_of(u)), 32'd1);
            check($sformatf("%s_pulses", tag), 32'({done_of(u), err_of(u)}), 32'd0);
            if (exp_lat > 0) check($sformatf("%s_lat", tag), 32'(n), 32'(exp_lat));
        end
    endtask

    // Wait for tx_done of the frame granted to id
    task automatic wait_done(input int u, input int id, input logic [7:0] d, input string tag);
        int n;
        int errs;
        bit seen;
        seen = 1'b0;
        n    = 0;
        errs = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (err_of(u)) errs++;
            if (ready_of(u) != 4'd0 || start_of(u)) stray++;
            if (done_of(u)) seen = 1'b1;
        end
        check($sformatf("%s_done", tag), 32'(seen), 32'd1);
        check($sformatf("%s_done_id", tag), 32'(gid_of(u)), 32'(id));
        check($sformatf("%s_done_data", tag), 32'(data_of(u)), 32'(d));
        check($sformatf("%s_done_idle", tag), 32'(active_of(u)), 32'd0);
        check($sformatf("%s_no_err", tag), 32'(errs), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int dn;
        bit seen;

        rst_n = 1'b0;
        req_valid4 = '0; req_mask4 = '0; req_data4 = '0;
        req_valid3 = '0; req_mask3 = '0; req_data3 = '0;
        busy_en4 = 1'b1; busy_en3 = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_out4", 32'({req_ready4, tx_data4, tx_start4, grant_id4, active4, tx_done4, err_timeout4}), 32'd0);
        check("rst_out3", 32'({req_ready3, tx_data3, tx_start3, grant_id3, active3, tx_done3, err_timeout3}), 32'd0);
        rst_n = 1'b1;

        // No eligible request: stays idle
        req_valid4 = 4'b0100; req_mask4 = 4'b1011;
        repeat (3) @(negedge clk);
        check("masked_idle", 32'({req_ready4, tx_start4, active4}), 32'd0);

        // Single request: requester 1 sends A5
        req_mask4  = 4'hF;
        req_data4  = 32'h0000_A500;
        req_valid4 = 4'b0010;
        push_exp(4, 1, 8'hA5);
        next_grant(4, 1, "single");
        req_valid4 = 4'b0000;
        @(negedge clk);
        check("single_pulse_end", 32'({req_ready4, tx_start4}), 32'd0);
        check("single_busy", 32'(tx_busy4), 32'd1);
        wait_done(4, 1, 8'hA5, "single");

        // Fairness: all valid, full mask, order 0,1,2,3,0,1
        do_reset();
        stray = 0;
        req_data4  = 32'h1312_1110;
        req_valid4 = 4'hF;
        for (int i = 0; i < 6; i++) begin
            push_exp(4, i % 4, 8'h10 + 8'(i % 4));
            next_grant(4, 1, $sformatf("fair%0d", i));
            wait_done(4, i % 4, 8'h10 + 8'(i % 4), $sformatf("fair%0d", i));
        end
        req_valid4 = 4'h0;
        check("fair_stray", 32'(stray), 32'd0);

        // Masking: mask 1011, order 0,1,3,0
        do_reset();
        stray = 0;
        req_mask4  = 4'b1011;
        req_valid4 = 4'hF;
        begin
            int ord[4] = '{0, 1, 3, 0};
            for (int i = 0; i < 4; i++) begin
                push_exp(4, ord[i], 8'h10 + 8'(ord[i]));
                next_grant(4, 1, $sformatf("mask%0d", i));
                wait_done(4, ord[i], 8'h10 + 8'(ord[i]), $sformatf("mask%0d", i));
            end
        end
        req_valid4 = 4'h0;
        req_mask4  = 4'hF;
        check("mask_stray", 32'(stray), 32'd0);

        // Timeout: transmitter never goes busy
        busy_en4   = 1'b0;
        req_data4  = 32'h4433_2211;
        req_valid4 = 4'b0100;
        push_exp(4, 2, 8'h33);
        next_grant(4, 1, "tmo");
        n = 0; dn = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (tx_done4) dn++;
            if (err_timeout4) seen = 1'b1;
        end
        check("tmo_seen", 32'(seen), 32'd1);
        check("tmo_cycles", 32'(n), 32'(TMO));
        check("tmo_no_done", 32'(dn), 32'd0);
        check("tmo_idle", 32'(active4), 32'd0);
        req_valid4 = 4'b1100;
        busy_en4   = 1'b1;
        push_exp(4, 3, 8'h44);
        next_grant(4, 1, "after_tmo");
        req_valid4 = 4'b0000;
        wait_done(4, 3, 8'h44, "after_tmo");

        // Reset in WAIT_DONE, then requesters 2 and 0: 0 first
        req_valid4 = 4'b0010;
        push_exp(4, 1, 8'h22);
        next_grant(4, 1, "pre_rst");
        req_valid4 = 4'b0000;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 32'({active4, tx_busy4}), 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out4", 32'({req_ready4, tx_data4, tx_start4, grant_id4, active4, tx_done4, err_timeout4}), 32'd0);
        @(negedge clk);
        check("mid_rst_hold", 32'({tx_done4, err_timeout4, active4}), 32'd0);
        rst_n = 1'b1;
        req_valid4 = 4'b0101;
        push_exp(4, 0, 8'h11);
        next_grant(4, 1, "post_rst");
        req_valid4 = 4'b0000;
        wait_done(4, 0, 8'h11, "post_rst");

        // Three requesters, all valid: 0,1,2,0
        stray = 0;
        req_mask3  = 3'b111;
        req_data3  = 24'h32_31_30;
        req_valid3 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            push_exp(3, i % 3, 8'h30 + 8'(i % 3));
            next_grant(3, 1, $sformatf("n3_%0d", i));
            wait_done(3, i % 3, 8'h30 + 8'(i % 3), $sformatf("n3_%0d", i));
        end
        req_valid3 = 3'b000;
        check("n3_stray", 32'(stray), 32'd0);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single UART transmitter among `NUM_REQ` byte producers. It accepts one byte per grant through a valid/ready handshake. It then drives the transmitter's `tx_data`/`tx_start` and tracks the transmitter's `tx_busy` until the frame completes. A watchdog recovers if the transmitter never acknowledges a start.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, at least 2.
- `DATA_BITS`, default 8: byte width; must match the transmitter.
- `BUSY_TIMEOUT`, default 16: cycles allowed between `tx_start` and `tx_busy` rising.
- `ID_W`, default `$clog2(NUM_REQ)`: grant ID width.

Ports (clock and reset: one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in `NUM_REQ`: per-requester byte available.
- `req_data` in `NUM_REQ*DATA_BITS`: requester i's byte in slice `[i*DATA_BITS +: DATA_BITS]`.
- `req_mask` in `NUM_REQ`: 1 means the requester is eligible.
- `req_ready` out `NUM_REQ`: one-cycle accept pulse, one-hot.
- `tx_data` out `DATA_BITS`: byte to the transmitter.
- `tx_start` out 1: one-cycle start pulse to the transmitter.
- `tx_busy` in 1: transmitter busy flag.
- `grant_id` out `ID_W`: current or last granted requester.
- `active` out 1: a transaction is in flight (state not IDLE).
- `tx_done` out 1: one-cycle pulse when a frame completes.
- `err_timeout` out 1: one-cycle pulse on watchdog expiry.

## Operation
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - The eligible set is `req_valid & req_mask`. If it is non-empty, pick the first eligible index searching `last+1, last+2, …` modulo `NUM_REQ`.
  - On that edge, register `grant_id`, load `tx_data` from the chosen slice, pulse `req_ready[g]` and `tx_start`, clear the watchdog, and go to WAIT_BUSY.
- WAIT_BUSY:
  - The watchdog increments each cycle.
  - If `tx_busy` is 1, go to WAIT_DONE.
  - Otherwise, when the count reaches `BUSY_TIMEOUT`: pulse `err_timeout`, set `last=g`, and go to IDLE. The byte is dropped and not re-requested.
- WAIT_DONE: on `tx_busy==0`, pulse `tx_done`, set `last=g`, and go to IDLE.
- `tx_data` and `grant_id` hold stable from issue until the next grant.
- `req_valid`, `req_data` and `req_mask` are sampled only in IDLE. Changes during WAIT_* have no effect on the current transaction.
- Reset value of `last` is `NUM_REQ-1`, so requester 0 has first priority.
- Width rules:
  - The watchdog counter is `$clog2(BUSY_TIMEOUT+1)` bits and saturates rather than wrapping.
  - The wrap-around index arithmetic must be correct for non-power-of-2 `NUM_REQ` (e.g. 3: `last=2` → search 0,1,2).

## Timing
- Reset values: all outputs 0, state IDLE, `last=NUM_REQ-1`, watchdog 0.
- Reset asserted mid-transaction aborts immediately. No `tx_done` or `err_timeout` is emitted for the aborted transaction.
- Edge k: IDLE with eligible request. In cycle k+1, `req_ready[g]`, `tx_start` and `active` are 1. `req_ready` and `tx_start` are 0 again in cycle k+2.
- With the standard transmitter, `tx_busy` rises in cycle k+2, so `err_timeout` never fires in normal operation.
- `tx_done` is high the cycle after the edge where `tx_busy==0` is seen in WAIT_DONE.
- Back-to-back throughput: the next grant can issue on the same edge as the `tx_done` transition is registered +1. There is a minimum of one IDLE cycle between transactions.
- A requester that keeps `req_valid` high is served at most once per round when others are eligible.
- If no request is eligible, the FSM stays in IDLE with all pulses 0.

## Structure
- Package `uart_arb_pkg`: state enum (IDLE, WAIT_BUSY, WAIT_DONE) and default parameter constants.
- Sub-module `uart_rr_picker`: combinational; inputs eligible vector and `last`; outputs `found` and `idx`.
- Top: FSM, watchdog, output registers.

## Test plan
- Single request: requester 1 sends 0xA5; the transmitter model raises `tx_busy` 1 cycle after `tx_start` for 20 cycles. Required: `req_ready=4'b0010` for one cycle, `tx_start` for one cycle, `tx_data=0xA5`, then `tx_done` with `grant_id=1`.
- Fairness: all 4 valid continuously, mask `4'hF`. Grant order is 0,1,2,3,0,1 with exactly one `req_ready` per grant.
- Masking: all valid, `req_mask=4'b1011`. Order is 0,1,3,0; requester 2 never gets `req_ready`.
- Timeout: `tx_busy` held 0 with requester 2 valid. `err_timeout` pulses exactly `BUSY_TIMEOUT` cycles after WAIT_BUSY entry, with no `tx_done`. The next grant, with 2 and 3 valid, goes to 3.
- Reset mid-frame: assert `rst_n=0` in WAIT_DONE. All outputs are 0 asynchronously. After release, with requesters 2 and 0 valid, 0 is granted first.
- `NUM_REQ=3`, all valid: grants 0,1,2,0. The wrap-around and `grant_id` width of 2 bits are checked.
